sig_deb: RTL and testbench
==========================

// Module: sig_deb
//
// PURPOSE
//   Debounces one asynchronous, bouncy input (pushbutton/switch) into a clean level.
//   Synchronises the input to clk and samples it once every CLKS_PER_SMPL cycles.
//   Output changes only after SMPL_CNT consecutive samples agree.
//   One instance per button; instances are replicated with generate loops.
//
// PARAMETERS
//   CLKS_PER_SMPL  16  clk cycles between samples; legal range >=1 (1 = sample every cycle)
//   SMPL_CNT       4   consecutive equal samples required to change o_sig; legal range >=2
//
// PORTS
//   clk    in   1  system clock; all logic on posedge
//   rst    in   1  reset, synchronous, active-high
//   i_sig  in   1  raw asynchronous input
//   o_sig  out  1  debounced level, registered
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge): sync FFs=0, tick counter=0, sample shift reg=0, o_sig=0.
//     Reset has priority over all other logic; asserting it mid-debounce discards all history.
//   - Synchroniser: 2-FF chain, i_sig -> s0 -> s1. Only s1 is used downstream (2-cycle delay).
//   - Tick counter: width $clog2(CLKS_PER_SMPL), minimum 1 bit. Counts 0..CLKS_PER_SMPL-1, then wraps to 0.
//     tick=1 when counter==CLKS_PER_SMPL-1; exactly one tick every CLKS_PER_SMPL cycles.
//     With CLKS_PER_SMPL=1, tick is constantly 1.
//   - Sample register smpl[SMPL_CNT-1:0]: on a tick cycle, nxt = {smpl[SMPL_CNT-2:0], s1}, then smpl<=nxt.
//     It holds on non-tick cycles.
//   - Output update, same edge as the shift: nxt all ones -> o_sig<=1; nxt all zeros -> o_sig<=0.
//     Any mix -> o_sig holds. o_sig never changes on non-tick cycles.
//   - Latency for a clean step on i_sig: at most 2 + SMPL_CNT*CLKS_PER_SMPL cycles.
//     At least 2 + (SMPL_CNT-1)*CLKS_PER_SMPL + 1 cycles.
//   - Glitch rejection: a pulse shorter than CLKS_PER_SMPL cycles covers at most one sample.
//     Such a pulse never changes o_sig.
//   - At most one o_sig transition per tick. No glitches on o_sig; it is a direct flop output.
//
// CONFIGURATION
//   SIG_DEB_EDGE_EN defined: adds outputs o_rise and o_fall (1 bit each, registered, reset 0).
//     Each is a single-cycle pulse, asserted the cycle after o_sig goes 0->1 or 1->0 respectively.
//   SIG_DEB_EDGE_EN undefined: these ports and their logic do not exist.
//     Users edge-detect o_sig externally.
//
// STRUCTURE
//   sig_deb_pkg: function clog2_min1(n) returning max(1, $clog2(n)).
//     Also holds constants SIG_DEB_DEF_CLKS_PER_SMPL=16 and SIG_DEB_DEF_SMPL_CNT=4.
//   Sub-module sig_deb_sync: 2-FF synchroniser (clk, rst, d, q), reset value 0.
//   Top: tick counter, sample shift register, output/edge flops.
//     Elaboration-time check rejects CLKS_PER_SMPL<1 or SMPL_CNT<2.
//
// TESTING  (defaults 16/4 unless noted)
//   1. rst=1 for 3 cycles, i_sig=1 -> o_sig=0 throughout reset.
//      Release rst, hold i_sig=1 -> o_sig rises between cycles 51 and 66 after release.
//   2. From o_sig=0: i_sig high for 10 cycles at arbitrary phase, then low for 200 cycles -> o_sig stays 0.
//   3. i_sig toggles every 5 cycles for 120 cycles, then holds 1 -> exactly one 0->1 on o_sig.
//      That transition comes within 66 cycles of the last toggle.
//   4. o_sig=1 steady, drive i_sig=0 -> o_sig falls within 66 cycles.
//      Assert rst during the next rising debounce -> o_sig=0 next cycle, and the count restarts from zero after release.
//   5. CLKS_PER_SMPL=1, SMPL_CNT=2, clean step on i_sig -> o_sig follows exactly 4 cycles later.
//      A 1-cycle glitch is rejected.
//   6. SIG_DEB_EDGE_EN defined: each o_sig transition yields exactly one 1-cycle o_rise or o_fall pulse.
//      No pulse appears while bouncing is rejected.

Source files
------------

// File: rtl/sig_deb_pkg.sv
// Shared constants and helpers for the sig_deb button debouncer.
package sig_deb_pkg;

    localparam int SIG_DEB_DEF_CLKS_PER_SMPL = 16;
    localparam int SIG_DEB_DEF_SMPL_CNT      = 4;

    // $clog2 but never below one bit, so a divide-by-1 counter still has a width.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sig_deb_sync.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sig_deb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s0;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/sig_deb.sv
// Debouncer: sync, sample every CLKS_PER_SMPL cycles, change after SMPL_CNT agreeing samples.
// Optional SIG_DEB_EDGE_EN adds registered o_rise/o_fall pulses.
module sig_deb
    import sig_deb_pkg::*;
#(
    parameter int CLKS_PER_SMPL = SIG_DEB_DEF_CLKS_PER_SMPL,
    parameter int SMPL_CNT      = SIG_DEB_DEF_SMPL_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_sig
`ifdef SIG_DEB_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall
`endif
);

    localparam int CW = clog2_min1(CLKS_PER_SMPL);

    if (CLKS_PER_SMPL < 1 || SMPL_CNT < 2) begin : g_bad_param
        $fatal(1, "sig_deb: need CLKS_PER_SMPL>=1 and SMPL_CNT>=2");
    end

    logic                s1;
    logic [CW-1:0]       tick_cnt;
    logic                tick;
    logic [SMPL_CNT-1:0] smpl;
    logic [SMPL_CNT-1:0] smpl_nxt;

    sig_deb_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_sig),
        .q   (s1)
    );

    assign tick = (tick_cnt == CW'(CLKS_PER_SMPL - 1));

    // Oldest sample falls off the top; newest enters at bit 0.
    always_comb begin
        smpl_nxt = (smpl << 1) | SMPL_CNT'(s1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            smpl     <= '0;
            o_sig    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                smpl <= smpl_nxt;
                if (&smpl_nxt)
                    o_sig <= 1'b1;
                else if (~|smpl_nxt)
                    o_sig <= 1'b0;
            end
        end
    end

`ifdef SIG_DEB_EDGE_EN
    logic o_sig_d;

    // Pulses land one cycle after o_sig moves; reset clears history so it never fakes a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sig_d <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
        end else begin
            o_sig_d <= o_sig;
            o_rise  <= o_sig & ~o_sig_d;
            o_fall  <= ~o_sig & o_sig_d;
        end
    end
`endif

endmodule

// File: tb/tb_sig_deb.sv
// Bench for sig_deb: a 16/4 instance and a 1/2 instance against a run-length reference model.
module tb_sig_deb;

    logic clk = 1'b0;
    logic rst_a, i_a, o_a;
    logic rst_b, i_b, o_b;
`ifdef SIG_DEB_EDGE_EN
    logic rise_a, fall_a, rise_b, fall_b;
    int   rise_cnt_a = 0, fall_cnt_a = 0;
`endif

    always #5 clk = ~clk;

    sig_deb #(.CLKS_PER_SMPL(16), .SMPL_CNT(4)) u_a (
        .clk   (clk),
        .rst   (rst_a),
        .i_sig (i_a),
        .o_sig (o_a)
`ifdef SIG_DEB_EDGE_EN
        ,
        .o_rise(rise_a),
        .o_fall(fall_a)
`endif
    );

    sig_deb #(.CLKS_PER_SMPL(1), .SMPL_CNT(2)) u_b (
        .clk   (clk),
        .rst   (rst_b),
        .i_sig (i_b),
        .o_sig (o_b)
`ifdef SIG_DEB_EDGE_EN
        ,
        .o_rise(rise_b),
        .o_fall(fall_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Drive values held between steps
    bit ra, xa, rb, xb;

    // Reference model: input seen two edges late, samples on every C-th edge,
    // output follows once the current run of equal samples reaches N.
    int       C_P[2] = '{16, 1};
    int       N_P[2] = '{4, 2};
    int       tcnt[2];
    bit [1:0] dly[2];
    bit       run_val[2];
    int       run_len[2];
    bit       eo[2], ed[2], er[2], ef[2];
    int       mrise[2] = '{0, 0};
    int       mfall[2] = '{0, 0};

    int  trans_a = 0, trans_b = 0;
    logic po_a = 1'b0, po_b = 1'b0;

    task automatic mdl(int id, bit r, bit x);
        bit s;
        if (r) begin
            tcnt[id] = 0; dly[id] = 2'b00;
            run_val[id] = 1'b0; run_len[id] = N_P[id];
            eo[id] = 1'b0; ed[id] = 1'b0; er[id] = 1'b0; ef[id] = 1'b0;
            return;
        end
        er[id] = eo[id] & ~ed[id];
        ef[id] = ~eo[id] & ed[id];
        ed[id] = eo[id];
        s = dly[id][1];
        dly[id] = {dly[id][0], x};
        if (tcnt[id] % C_P[id] == C_P[id] - 1) begin
            if (s == run_val[id]) run_len[id]++;
            else begin run_val[id] = s; run_len[id] = 1; end
            if (run_len[id] >= N_P[id] && eo[id] != run_val[id]) begin
                eo[id] = run_val[id];
                if (run_val[id]) mrise[id]++; else mfall[id]++;
            end
        end
        tcnt[id]++;
    endtask

    task automatic chk(string tag, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_rng(string tag, int got, int lo, int hi);
        checks++;
        assert ((got >= lo && got <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // One clock: apply held inputs, advance model, compare #1 after the edge.
    task automatic cyc();
        rst_a = ra; i_a = xa; rst_b = rb; i_b = xb;
        @(posedge clk);
        mdl(0, ra, xa);
        mdl(1, rb, xb);
        #1;
        chk("o_sig_a", o_a, eo[0]);
        chk("o_sig_b", o_b, eo[1]);
`ifdef SIG_DEB_EDGE_EN
        chk("o_rise_a", rise_a, er[0]);
        chk("o_fall_a", fall_a, ef[0]);
        chk("o_rise_b", rise_b, er[1]);
        chk("o_fall_b", fall_b, ef[1]);
        if (rise_a === 1'b1) rise_cnt_a++;
        if (fall_a === 1'b1) fall_cnt_a++;
`endif
        if (o_a !== po_a) trans_a++;
        if (o_b !== po_b) trans_b++;
        po_a = o_a; po_b = o_b;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Bounded wait for an instance output to reach val; t = edges taken.
    task automatic wait_o(int id, bit val, output int t);
        t = 0;
        do begin
            cyc();
            t++;
        end while (((id == 0) ? o_a : o_b) !== val && t < 200);
    endtask

    initial begin
        int t, t0, la, lb;

        // Reset with input high: output held low
        ra = 1; xa = 1; rb = 1; xb = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_o_a", o_a, 1'b0);
        end
        ra = 0; rb = 0;
        wait_o(0, 1'b1, t);
        chk_rng("rise_after_rst", t, 51, 66);

        // Short high pulse at random phase is rejected
        xa = 0;
        wait_o(0, 1'b0, t);
        chk_rng("clean_fall", t, 51, 66);
        run($urandom_range(0, 15));
        t0 = trans_a;
        xa = 1; run(10);
        xa = 0; run(200);
        chk_rng("pulse_rejected", trans_a - t0, 0, 0);
        chk("pulse_o_low", o_a, 1'b0);

        // Bouncing every 5 cycles, then settle high
        t0 = trans_a;
        xa = 0;
        for (int i = 0; i < 24; i++) begin
            run(5);
            if (i < 23) xa = ~xa;
        end
        wait_o(0, 1'b1, t);
        chk_rng("bounce_latency", t + 5, 1, 66);
        run(80);
        chk_rng("bounce_one_edge", trans_a - t0, 1, 1);

        // Clean fall, then reset mid rising debounce
        xa = 0;
        wait_o(0, 1'b0, t);
        chk_rng("fall_latency", t, 51, 66);
        xa = 1; run(30);
        ra = 1; cyc();
        chk("mid_rst_o", o_a, 1'b0);
        ra = 0;
        wait_o(0, 1'b1, t);
        chk_rng("rise_after_mid_rst", t, 64, 64);

        // Fast instance: 4-edge step response and 1-cycle glitch rejection
        xb = 1;
        wait_o(1, 1'b1, t);
        chk_rng("b_rise_lat", t, 4, 4);
        run(5);
        t0 = trans_b;
        xb = 0; cyc(); xb = 1; run(10);
        chk_rng("b_glitch_lo", trans_b - t0, 0, 0);
        xb = 0;
        wait_o(1, 1'b0, t);
        chk_rng("b_fall_lat", t, 4, 4);
        run(5);
        t0 = trans_b;
        xb = 1; cyc(); xb = 0; run(10);
        chk_rng("b_glitch_hi", trans_b - t0, 0, 0);

        // Random bouncing on both instances with occasional resets
        la = 1; lb = 1;
        for (int i = 0; i < 3000; i++) begin
            if (--la == 0) begin xa = 1'($urandom_range(0, 1)); la = $urandom_range(1, 40); end
            if (--lb == 0) begin xb = 1'($urandom_range(0, 1)); lb = $urandom_range(1, 3); end
            ra = ($urandom_range(0, 499) == 0);
            rb = ($urandom_range(0, 499) == 0);
            cyc();
        end
        ra = 0; rb = 0; run(80);

`ifdef SIG_DEB_EDGE_EN
        chk_rng("rise_pulses", rise_cnt_a, mrise[0], mrise[0]);
        chk_rng("fall_pulses", fall_cnt_a, mfall[0], mfall[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
